timer_flow_status: RTL and testbench

//  Downstream of the timer counter. Samples the 8-bit counter value each clk and keeps the previous value.

---
 rtl/timer_flow_status.sv | 115 +++++++++++
 tb/tb_timer_flow_status.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_flow_status.sv
// Overflow/underflow detection, sticky status (TSR), interrupt enables (TIER) and interrupt lines for the timer.
// Optional flow-event history register is enabled with `define TIMER_FLOW_HIST_EN.
module timer_flow_status #(
  parameter logic [7:0] TSR_ADDR  = 8'h02,
  parameter logic [7:0] TIER_ADDR = 8'h03,
  parameter logic [7:0] HIST_ADDR = 8'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cnt,
  input  logic       cnt_loaded,
  input  logic       cnt_dir,
  input  logic       cnt_en,
  input  logic       sel,
  input  logic       wr_en,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       tmr_ovf,
  output logic       tmr_udf
);

  localparam int unsigned DW = 8;
  localparam int unsigned FW = 2;

  logic [DW-1:0] last_cnt;
  logic [FW-1:0] tsr;
  logic [FW-1:0] tier;
  logic [FW-1:0] tsr_nxt;
  logic          ovf_det;
  logic          udf_det;
  logic          tsr_wr;
  logic          tier_wr;
  logic          unused_wdata;

  assign unused_wdata = ^wdata[DW-1:FW];

  // Wrap detection; loaded values and a stopped counter never count as a step.
  assign ovf_det = cnt_en & ~cnt_dir & ~cnt_loaded & (last_cnt == 8'hFF) & (cnt == 8'h00);
  assign udf_det = cnt_en &  cnt_dir & ~cnt_loaded & (last_cnt == 8'h00) & (cnt == 8'hFF);

  assign tsr_wr  = sel & wr_en & (addr == TSR_ADDR);
  assign tier_wr = sel & wr_en & (addr == TIER_ADDR);

  // Write-0-to-clear, with a same-cycle detection taking priority.
  always_comb begin
    tsr_nxt = tsr;
    if (tsr_wr) tsr_nxt = tsr & wdata[FW-1:0];
    tsr_nxt = tsr_nxt | {udf_det, ovf_det};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cnt <= '0;
      tsr      <= '0;
      tier     <= '0;
      tmr_ovf  <= 1'b0;
      tmr_udf  <= 1'b0;
    end else begin
      last_cnt <= cnt;
      tsr      <= tsr_nxt;
      if (tier_wr) tier <= wdata[FW-1:0];
      tmr_ovf  <= tsr[0] & tier[0];
      tmr_udf  <= tsr[1] & tier[1];
    end
  end

`ifdef TIMER_FLOW_HIST_EN
  localparam int unsigned HW = 4;

  logic [HW-1:0] hist_ovf;
  logic [HW-1:0] hist_udf;
  logic          hist_clr;

  assign hist_clr = sel & wr_en & (addr == HIST_ADDR);

  // Saturating event count; a detection coinciding with a clear restarts at 1.
  function automatic logic [HW-1:0] hist_step(input logic [HW-1:0] c, input logic clr,
                                              input logic det);
    logic [HW-1:0] r;
    r = c;
    if (clr)                  r = det ? HW'(1) : '0;
    else if (det && c != '1)  r = c + HW'(1);
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_ovf <= '0;
      hist_udf <= '0;
    end else begin
      hist_ovf <= hist_step(hist_ovf, hist_clr, ovf_det);
      hist_udf <= hist_step(hist_udf, hist_clr, udf_det);
    end
  end
`endif

  // Zero-wait-state read mux.
  always_comb begin
    rdata = '0;
    if (sel && !wr_en) begin
      case (addr)
        TSR_ADDR:  rdata = {(DW-FW)'(0), tsr};
        TIER_ADDR: rdata = {(DW-FW)'(0), tier};
`ifdef TIMER_FLOW_HIST_EN
        HIST_ADDR: rdata = {hist_udf, hist_ovf};
`else
        HIST_ADDR: rdata = '0;
`endif
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_flow_status.sv
// Vector table plus hand sequences for timer_flow_status; expected outputs queued and checked each cycle.
module tb_timer_flow_status;

  typedef struct {
    int         id;
    logic [7:0] cnt;
    logic       ld, dir, en, sel, wr;
    logic [7:0] addr, wdata, e_rdata;
    logic       e_ovf, e_udf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cnt = '0;
  logic       cnt_loaded = 1'b0, cnt_dir = 1'b0, cnt_en = 1'b0;
  logic       sel = 1'b0, wr_en = 1'b0;
  logic [7:0] addr = '0, wdata = '0;
  logic [7:0] rdata;
  logic       tmr_ovf, tmr_udf;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  timer_flow_status dut (
    .clk(clk), .rst_n(rst_n), .cnt(cnt), .cnt_loaded(cnt_loaded), .cnt_dir(cnt_dir),
    .cnt_en(cnt_en), .sel(sel), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tmr_ovf(tmr_ovf), .tmr_udf(tmr_udf)
  );

  function automatic vec_t mk(input logic [7:0] c, input logic l, input logic d, input logic e,
                              input logic s, input logic w, input logic [7:0] a,
                              input logic [7:0] wd, input logic [7:0] er,
                              input logic eo, input logic eu);
    vec_t v;
    v.id = 0; v.cnt = c; v.ld = l; v.dir = d; v.en = e; v.sel = s; v.wr = w;
    v.addr = a; v.wdata = wd; v.e_rdata = er; v.e_ovf = eo; v.e_udf = eu;
    return v;
  endfunction

  function automatic vec_t rd(input logic [7:0] c, input logic l, input logic d, input logic e,
                              input logic [7:0] a, input logic [7:0] er,
                              input logic eo, input logic eu);
    return mk(c, l, d, e, 1'b1, 1'b0, a, 8'h00, er, eo, eu);
  endfunction

  function automatic vec_t wr(input logic [7:0] c, input logic l, input logic d, input logic e,
                              input logic [7:0] a, input logic [7:0] wd,
                              input logic eo, input logic eu);
    return mk(c, l, d, e, 1'b1, 1'b1, a, wd, 8'h00, eo, eu);
  endfunction

  function automatic vec_t nb(input logic [7:0] c, input logic l, input logic d, input logic e,
                              input logic eo, input logic eu);
    return mk(c, l, d, e, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, eo, eu);
  endfunction

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Compare the oldest queued expectation against the outputs seen this cycle.
  task automatic check_out();
    vec_t e;
    e = sb.pop_front();
    n_vec++;
    if (rdata !== e.e_rdata || tmr_ovf !== e.e_ovf || tmr_udf !== e.e_udf) begin
      n_err++;
      $display("FAIL vec%0d: rdata/ovf/udf got %h/%b/%b expected %h/%b/%b",
               e.id, rdata, tmr_ovf, tmr_udf, e.e_rdata, e.e_ovf, e.e_udf);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    cnt = v.cnt; cnt_loaded = v.ld; cnt_dir = v.dir; cnt_en = v.en;
    sel = v.sel; wr_en = v.wr; addr = v.addr; wdata = v.wdata;
    sb.push_back(v);
    #2;
    check_out();
  endtask

  task automatic run_queue();
    int k;
    k = 0;
    while (vecs.size() > 0) begin
      vec_t v;
      v = vecs.pop_front();
      v.id = k;
      k++;
      apply(v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hist_exp;
`ifdef TIMER_FLOW_HIST_EN
    hist_exp = 8'h13;
`else
    hist_exp = 8'h00;
`endif
    // reset state and reads
    vecs.push_back(rd(8'h00, 0, 0, 0, 8'h02, 8'h00, 0, 0));
    vecs.push_back(rd(8'h00, 0, 0, 0, 8'h03, 8'h00, 0, 0));
    vecs.push_back(rd(8'h00, 0, 0, 0, 8'h04, 8'h00, 0, 0));
    // loads 00 then FF counting down: no flag
    vecs.push_back(nb(8'h00, 1, 1, 1, 0, 0));
    vecs.push_back(nb(8'hFF, 1, 1, 1, 0, 0));
    vecs.push_back(rd(8'hFF, 0, 1, 1, 8'h02, 8'h00, 0, 0));
    // stopped counter changing: no flag
    vecs.push_back(rd(8'h00, 0, 0, 0, 8'h02, 8'h00, 0, 0));
    vecs.push_back(rd(8'hFF, 0, 1, 0, 8'h02, 8'h00, 0, 0));
    vecs.push_back(rd(8'hFF, 0, 0, 1, 8'h02, 8'h00, 0, 0));
    // count up through wrap with TIER=01
    vecs.push_back(wr(8'hFE, 0, 0, 1, 8'h03, 8'h01, 0, 0));
    vecs.push_back(rd(8'hFF, 0, 0, 1, 8'h03, 8'h01, 0, 0));
    vecs.push_back(rd(8'h00, 0, 0, 1, 8'h02, 8'h00, 0, 0));
    vecs.push_back(rd(8'h01, 0, 0, 1, 8'h02, 8'h01, 0, 0));
    vecs.push_back(rd(8'h02, 0, 0, 1, 8'h02, 8'h01, 1, 0));
    vecs.push_back(wr(8'h03, 0, 0, 1, 8'h02, 8'h00, 1, 0));
    vecs.push_back(rd(8'h04, 0, 0, 1, 8'h02, 8'h00, 1, 0));
    vecs.push_back(rd(8'h05, 0, 0, 1, 8'h02, 8'h00, 0, 0));
    // count down through wrap with TIER=00, then enable
    vecs.push_back(wr(8'h01, 0, 1, 1, 8'h03, 8'h00, 0, 0));
    vecs.push_back(rd(8'h00, 0, 1, 1, 8'h03, 8'h00, 0, 0));
    vecs.push_back(rd(8'hFF, 0, 1, 1, 8'h02, 8'h00, 0, 0));
    vecs.push_back(rd(8'hFE, 0, 1, 1, 8'h02, 8'h02, 0, 0));
    vecs.push_back(wr(8'hFD, 0, 1, 1, 8'h03, 8'h02, 0, 0));
    vecs.push_back(rd(8'hFC, 0, 1, 1, 8'h03, 8'h02, 0, 0));
    vecs.push_back(rd(8'hFB, 0, 1, 1, 8'h02, 8'h02, 0, 1));
    vecs.push_back(wr(8'hFA, 0, 1, 1, 8'h02, 8'hFF, 0, 1));
    vecs.push_back(rd(8'hF9, 0, 1, 1, 8'h02, 8'h02, 0, 1));
    vecs.push_back(wr(8'hF8, 0, 1, 1, 8'h03, 8'h00, 0, 1));
    vecs.push_back(rd(8'hF7, 0, 1, 1, 8'h02, 8'h02, 0, 1));
    vecs.push_back(rd(8'hF6, 0, 1, 1, 8'h03, 8'h00, 0, 0));
    // set beats clear on the same bit
    vecs.push_back(wr(8'hFF, 1, 0, 1, 8'h03, 8'hFF, 0, 0));
    vecs.push_back(rd(8'h00, 0, 0, 1, 8'h03, 8'h03, 0, 0));
    vecs.push_back(rd(8'hFF, 1, 0, 1, 8'h02, 8'h03, 0, 1));
    vecs.push_back(wr(8'h00, 0, 0, 1, 8'h02, 8'hFE, 1, 1));
    vecs.push_back(rd(8'h01, 0, 0, 1, 8'h02, 8'h03, 1, 1));
    vecs.push_back(wr(8'h02, 0, 0, 1, 8'h02, 8'h01, 1, 1));
    vecs.push_back(rd(8'h03, 0, 0, 1, 8'h02, 8'h01, 1, 1));
    vecs.push_back(rd(8'h04, 0, 0, 1, 8'h02, 8'h01, 1, 0));
    // unmapped address, deselected read, history address
    vecs.push_back(rd(8'h05, 0, 0, 1, 8'h05, 8'h00, 1, 0));
    vecs.push_back(mk(8'h06, 0, 0, 1, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00, 1, 0));
    vecs.push_back(rd(8'h07, 0, 0, 1, 8'h04, hist_exp, 1, 0));

    @(negedge clk);
    rst_n = 1'b1;
    run_queue();

    // asynchronous reset mid-cycle with flags and interrupt set
    @(negedge clk);
    cnt = 8'h08; cnt_loaded = 1'b0; cnt_dir = 1'b0; cnt_en = 1'b1;
    sel = 1'b1; wr_en = 1'b0; addr = 8'h02; wdata = 8'h00;
    #2;
    chk8("pre_rst_tsr", rdata, 8'h01);
    chk1("pre_rst_ovf", tmr_ovf, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk8("rst_tsr", rdata, 8'h00);
    chk1("rst_ovf", tmr_ovf, 1'b0);
    chk1("rst_udf", tmr_udf, 1'b0);
    addr = 8'h03;
    #0.5;
    chk8("rst_tier", rdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef TIMER_FLOW_HIST_EN
    // 17 overflows saturate, then clear coinciding with a detection
    for (int i = 0; i < 17; i++) begin
      vecs.push_back(nb(8'hFF, 1, 0, 1, 0, 0));
      vecs.push_back(nb(8'h00, 0, 0, 1, 0, 0));
    end
    vecs.push_back(rd(8'h00, 0, 0, 1, 8'h04, 8'h0F, 0, 0));
    vecs.push_back(nb(8'hFF, 1, 0, 1, 0, 0));
    vecs.push_back(wr(8'h00, 0, 0, 1, 8'h04, 8'h00, 0, 0));
    vecs.push_back(rd(8'h01, 0, 0, 1, 8'h04, 8'h01, 0, 0));
    vecs.push_back(nb(8'h00, 1, 1, 1, 0, 0));
    vecs.push_back(rd(8'hFF, 0, 1, 1, 8'h04, 8'h01, 0, 0));
    vecs.push_back(rd(8'hFE, 0, 1, 1, 8'h04, 8'h11, 0, 0));
`else
    vecs.push_back(nb(8'hFF, 1, 0, 1, 0, 0));
    vecs.push_back(wr(8'h00, 0, 0, 1, 8'h04, 8'hFF, 0, 0));
    vecs.push_back(rd(8'h01, 0, 0, 1, 8'h04, 8'h00, 0, 0));
    vecs.push_back(rd(8'h02, 0, 0, 1, 8'h02, 8'h01, 0, 0));
`endif
    run_queue();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
